// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_pkg
//  Description : Scancodes, key indices, parser state encoding and the
//                scancode-to-key lookup shared by the keyboard decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    // Sequence prefix bytes
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_F0    = 8'hF0;

    // Game key scancodes (P1 and Enter are plain, P2 keys are E0-extended)
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam int NUM_KEYS = 11;

    // Bit positions in the held vector
    localparam logic [3:0] KEY_P1_UP    = 4'd0;
    localparam logic [3:0] KEY_P1_LEFT  = 4'd1;
    localparam logic [3:0] KEY_P1_DOWN  = 4'd2;
    localparam logic [3:0] KEY_P1_RIGHT = 4'd3;
    localparam logic [3:0] KEY_P1_BOMB  = 4'd4;
    localparam logic [3:0] KEY_P2_UP    = 4'd5;
    localparam logic [3:0] KEY_P2_LEFT  = 4'd6;
    localparam logic [3:0] KEY_P2_DOWN  = 4'd7;
    localparam logic [3:0] KEY_P2_RIGHT = 4'd8;
    localparam logic [3:0] KEY_P2_BOMB  = 4'd9;
    localparam logic [3:0] KEY_START    = 4'd10;

    // Bytes that follow the E1 that opens a Pause sequence
    localparam logic [2:0] SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } parse_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } key_hit_t;

    // Map a completed scancode (with its extended flag) onto a key index
    function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
        key_hit_t r;
        r.valid = 1'b1;
        r.idx   = 4'd0;
        if (!ext) begin
            case (code)
                SC_W:     r.idx = KEY_P1_UP;
                SC_A:     r.idx = KEY_P1_LEFT;
                SC_S:     r.idx = KEY_P1_DOWN;
                SC_D:     r.idx = KEY_P1_RIGHT;
                SC_SPACE: r.idx = KEY_P1_BOMB;
                SC_ENTER: r.idx = KEY_START;
                default:  r.valid = 1'b0;
            endcase
        end else begin
            case (code)
                SC_UP:    r.idx = KEY_P2_UP;
                SC_LEFT:  r.idx = KEY_P2_LEFT;
                SC_DOWN:  r.idx = KEY_P2_DOWN;
                SC_RIGHT: r.idx = KEY_P2_RIGHT;
                SC_CTRL:  r.idx = KEY_P2_BOMB;
                default:  r.valid = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scancode_parser.sv
`default_nettype none
// ============================================================================
//  Module      : scancode_parser
//  Description : Splits the PS/2 byte stream into make/break events with an
//                extended flag; swallows Pause sequences and abandons partial
//                sequences after an idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module scancode_parser
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int TO_W           = 19
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] byte_in,
    input  logic       byte_en,
    input  logic       clear,
    output logic [7:0] code,
    output logic       ext,
    output logic       brk,
    output logic       code_valid
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    parse_state_t    state, state_nx;
    logic [2:0]      skip_cnt, skip_nx;
    logic [TO_W-1:0] to_cnt, to_nx;

    // Next state; the decoded event is combinational so the top can register
    // the held/pulse update on the same edge that ends the strobe cycle.
    always_comb begin
        state_nx   = state;
        skip_nx    = skip_cnt;
        to_nx      = to_cnt;
        code       = byte_in;
        ext        = 1'b0;
        brk        = 1'b0;
        code_valid = 1'b0;
        if (clear) begin
            state_nx = ST_IDLE;
            skip_nx  = '0;
            to_nx    = '0;
        end else if (byte_en) begin
            to_nx = '0;
            case (state)
                ST_IDLE: begin
                    if (byte_in == SC_E0) begin
                        state_nx = ST_EXT;
                    end else if (byte_in == SC_F0) begin
                        state_nx = ST_BRK;
                    end else if (byte_in == SC_E1) begin
                        state_nx = ST_SKIP;
                        skip_nx  = SKIP_LEN;
                    end else begin
                        code_valid = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (byte_in == SC_F0) begin
                        state_nx = ST_EXT_BRK;
                    end else begin
                        code_valid = 1'b1;
                        ext        = 1'b1;
                        state_nx   = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    code_valid = 1'b1;
                    brk        = 1'b1;
                    state_nx   = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    code_valid = 1'b1;
                    brk        = 1'b1;
                    ext        = 1'b1;
                    state_nx   = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_nx = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_nx  = '0;
                        state_nx = ST_IDLE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (to_cnt == TO_LAST) begin
                state_nx = ST_IDLE;
                skip_nx  = '0;
                to_nx    = '0;
            end else begin
                to_nx = to_cnt + 1'b1;
            end
        end
    end

    // Parser state, skip counter and timeout counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
            to_cnt   <= to_nx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keyboard_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_decoder
//  Description : Turns parsed scancode events into held-key state, per-player
//                movement controls and one-shot bomb/start pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module keyboard_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int TO_W           = 19
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [7:0]          ps2_byte,
    input  logic                ps2_byte_en,
    input  logic                clear_keys,
    output logic                p1_xmov,
    output logic                p1_xdir,
    output logic                p1_ymov,
    output logic                p1_ydir,
    output logic                p2_xmov,
    output logic                p2_xdir,
    output logic                p2_ymov,
    output logic                p2_ydir,
    output logic                p1_bomb,
    output logic                p2_bomb,
    output logic                start,
    output logic [NUM_KEYS-1:0] held
);

    logic [7:0]          code;
    logic                ext;
    logic                brk;
    logic                code_valid;
    key_hit_t            hit;
    logic [NUM_KEYS-1:0] onehot;
    logic [NUM_KEYS-1:0] held_nx;
    logic                was_held;
    logic                p1_bomb_nx;
    logic                p2_bomb_nx;
    logic                start_nx;

    scancode_parser #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_parser (
        .clock      (clock),
        .reset_n    (reset_n),
        .byte_in    (ps2_byte),
        .byte_en    (ps2_byte_en),
        .clear      (clear_keys),
        .code       (code),
        .ext        (ext),
        .brk        (brk),
        .code_valid (code_valid)
    );

    // Held-vector update and edge-detected pulses; typematic repeats of an
    // already-held key leave held unchanged and fire nothing.
    always_comb begin
        hit        = key_lookup(code, ext);
        onehot     = {{(NUM_KEYS-1){1'b0}}, 1'b1} << hit.idx;
        was_held   = |(held & onehot);
        held_nx    = held;
        p1_bomb_nx = 1'b0;
        p2_bomb_nx = 1'b0;
        start_nx   = 1'b0;
        if (code_valid && hit.valid) begin
            if (brk) begin
                held_nx = held & ~onehot;
            end else begin
                held_nx = held | onehot;
                if (!was_held) begin
                    p1_bomb_nx = (hit.idx == KEY_P1_BOMB);
                    p2_bomb_nx = (hit.idx == KEY_P2_BOMB);
                    start_nx   = (hit.idx == KEY_START);
                end
            end
        end
    end

    // Held keys and pulse registers; clear_keys wipes both without a pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held    <= '0;
            p1_bomb <= 1'b0;
            p2_bomb <= 1'b0;
            start   <= 1'b0;
        end else if (clear_keys) begin
            held    <= '0;
            p1_bomb <= 1'b0;
            p2_bomb <= 1'b0;
            start   <= 1'b0;
        end else begin
            held    <= held_nx;
            p1_bomb <= p1_bomb_nx;
            p2_bomb <= p2_bomb_nx;
            start   <= start_nx;
        end
    end

    // Opposing keys on one axis cancel; dir is 1 toward increasing coordinate
    assign p1_xmov = held[KEY_P1_LEFT] ^ held[KEY_P1_RIGHT];
    assign p1_xdir = held[KEY_P1_RIGHT] & ~held[KEY_P1_LEFT];
    assign p1_ymov = held[KEY_P1_UP] ^ held[KEY_P1_DOWN];
    assign p1_ydir = held[KEY_P1_DOWN] & ~held[KEY_P1_UP];
    assign p2_xmov = held[KEY_P2_LEFT] ^ held[KEY_P2_RIGHT];
    assign p2_xdir = held[KEY_P2_RIGHT] & ~held[KEY_P2_LEFT];
    assign p2_ymov = held[KEY_P2_UP] ^ held[KEY_P2_DOWN];
    assign p2_ydir = held[KEY_P2_DOWN] & ~held[KEY_P2_UP];

endmodule
`default_nettype wire

// File: tb/tb_keyboard_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keyboard_decoder
//  Description : Self-checking bench: directed vector table, hand-written
//                timeout/reset sequences and randomized traffic against a
//                sequence-buffer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keyboard_decoder;

    localparam int T = 16;

    // Held-vector bit meanings
    localparam logic [10:0] H_W  = 11'h001;
    localparam logic [10:0] H_A  = 11'h002;
    localparam logic [10:0] H_S  = 11'h004;
    localparam logic [10:0] H_D  = 11'h008;
    localparam logic [10:0] H_SP = 11'h010;
    localparam logic [10:0] H_UP = 11'h020;
    localparam logic [10:0] H_LF = 11'h040;
    localparam logic [10:0] H_DN = 11'h080;
    localparam logic [10:0] H_RT = 11'h100;
    localparam logic [10:0] H_CT = 11'h200;
    localparam logic [10:0] H_EN = 11'h400;
    // Pulse bits {p1_bomb, p2_bomb, start}
    localparam logic [2:0] P_B1 = 3'b100;
    localparam logic [2:0] P_B2 = 3'b010;
    localparam logic [2:0] P_ST = 3'b001;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  ps2_byte = 8'h00;
    logic        ps2_byte_en = 1'b0;
    logic        clear_keys = 1'b0;
    logic        p1_xmov, p1_xdir, p1_ymov, p1_ydir;
    logic        p2_xmov, p2_xdir, p2_ymov, p2_ydir;
    logic        p1_bomb, p2_bomb, start;
    logic [10:0] held;

    int errors = 0;
    int checks = 0;

    keyboard_decoder #(
        .TIMEOUT_CYCLES (T),
        .TO_W           (5)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ps2_byte    (ps2_byte),
        .ps2_byte_en (ps2_byte_en),
        .clear_keys  (clear_keys),
        .p1_xmov     (p1_xmov),
        .p1_xdir     (p1_xdir),
        .p1_ymov     (p1_ymov),
        .p1_ydir     (p1_ydir),
        .p2_xmov     (p2_xmov),
        .p2_xdir     (p2_xdir),
        .p2_ymov     (p2_ymov),
        .p2_ydir     (p2_ydir),
        .p1_bomb     (p1_bomb),
        .p2_bomb     (p2_bomb),
        .start       (start),
        .held        (held)
    );

    always #5 clock = ~clock;

    // Movement derived from the held keys by the axis rules, then pulses, then held
    function automatic logic [21:0] expect_vec(input logic [10:0] h, input logic [2:0] p);
        logic u1, l1, d1, r1, u2, l2, d2, r2;
        u1 = h[0]; l1 = h[1]; d1 = h[2]; r1 = h[3];
        u2 = h[5]; l2 = h[6]; d2 = h[7]; r2 = h[8];
        return {l1 != r1, r1 && !l1, u1 != d1, d1 && !u1,
                l2 != r2, r2 && !l2, u2 != d2, d2 && !u2, p, h};
    endfunction

    task automatic check(input string name, input logic [10:0] eh, input logic [2:0] ep);
        logic [21:0] act, exp;
        act = {p1_xmov, p1_xdir, p1_ymov, p1_ydir, p2_xmov, p2_xdir, p2_ymov, p2_ydir,
               p1_bomb, p2_bomb, start, held};
        exp = expect_vec(eh, ep);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got mov=%b pulse=%b held=%h, want mov=%b pulse=%b held=%h",
                     name, act[21:14], act[13:11], act[10:0], exp[21:14], exp[13:11], exp[10:0]);
        end
    endtask

    // ---------------- reference model: buffer the bytes of one sequence ----
    logic [7:0]  q[$];
    logic [10:0] m_held;
    logic [2:0]  m_pulse;
    int          idle;

    function automatic logic [10:0] key_mask(input logic ext, input logic [7:0] c);
        logic [7:0]  plain_codes[6] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A};
        logic [10:0] plain_masks[6] = '{H_W, H_A, H_S, H_D, H_SP, H_EN};
        logic [7:0]  ext_codes[5]   = '{8'h75, 8'h6B, 8'h72, 8'h74, 8'h14};
        logic [10:0] ext_masks[5]   = '{H_UP, H_LF, H_DN, H_RT, H_CT};
        if (!ext) begin
            for (int i = 0; i < 6; i++) if (plain_codes[i] == c) return plain_masks[i];
        end else begin
            for (int i = 0; i < 5; i++) if (ext_codes[i] == c) return ext_masks[i];
        end
        return 11'h000;
    endfunction

    function automatic void model_eval();
        int n;
        logic ext, brk;
        logic [10:0] m;
        n = q.size();
        if (q[0] == 8'hE1) begin
            if (n == 8) q.delete();
            return;
        end
        if (n == 1 && (q[0] == 8'hE0 || q[0] == 8'hF0)) return;
        if (n == 2 && q[0] == 8'hE0 && q[1] == 8'hF0) return;
        ext = (q[0] == 8'hE0);
        brk = (n >= 2) && (q[n-2] == 8'hF0);
        m = key_mask(ext, q[n-1]);
        q.delete();
        if (m == 0) return;
        if (brk) begin
            m_held = m_held & ~m;
        end else begin
            if ((m_held & m) == 0) begin
                if (m == H_SP) m_pulse = P_B1;
                if (m == H_CT) m_pulse = P_B2;
                if (m == H_EN) m_pulse = P_ST;
            end
            m_held = m_held | m;
        end
    endfunction

    function automatic void model_step(input logic clr, input logic en, input logic [7:0] b);
        m_pulse = 3'b000;
        if (clr) begin
            q.delete();
            m_held = '0;
            idle = 0;
        end else if (en) begin
            if (idle >= T) q.delete();
            idle = 0;
            q.push_back(b);
            model_eval();
        end else begin
            idle++;
        end
    endfunction

    // Drive one cycle from a negedge and return at the following negedge
    task automatic cycle(input logic clr, input logic en, input logic [7:0] b);
        clear_keys  = clr;
        ps2_byte_en = en;
        ps2_byte    = b;
        model_step(clr, en, b);
        @(posedge clock);
        @(negedge clock);
        clear_keys  = 1'b0;
        ps2_byte_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b0, 1'b1, b);
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic        clr;
        logic        en;
        logic [7:0]  b;
        logic [10:0] held;
        logic [2:0]  pulse;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic clr, input logic en, input logic [7:0] b,
                                input logic [10:0] h, input logic [2:0] p);
        vec_t v;
        v.clr = clr; v.en = en; v.b = b; v.held = h; v.pulse = p;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // W make/break
        add(0,1,8'h1D,H_W,0); add(0,1,8'hF0,H_W,0); add(0,1,8'h1D,0,0);
        // P2 right, then left as well (cancel), release right, release left
        add(0,1,8'hE0,0,0); add(0,1,8'h74,H_RT,0);
        add(0,1,8'hE0,H_RT,0); add(0,1,8'h6B,H_RT|H_LF,0);
        add(0,1,8'hE0,H_RT|H_LF,0); add(0,1,8'hF0,H_RT|H_LF,0); add(0,1,8'h74,H_LF,0);
        add(0,1,8'hE0,H_LF,0); add(0,1,8'hF0,H_LF,0); add(0,1,8'h6B,0,0);
        // Space typematic: one pulse per fresh press
        add(0,1,8'h29,H_SP,P_B1); add(0,0,8'h00,H_SP,0);
        add(0,1,8'h29,H_SP,0); add(0,1,8'h29,H_SP,0);
        add(0,1,8'hF0,H_SP,0); add(0,1,8'h29,0,0);
        add(0,1,8'h29,H_SP,P_B1); add(0,0,8'h00,H_SP,0);
        add(0,1,8'hF0,H_SP,0); add(0,1,8'h29,0,0);
        // Right Ctrl bombs for P2, left Ctrl does nothing
        add(0,1,8'hE0,0,0); add(0,1,8'h14,H_CT,P_B2); add(0,0,8'h00,H_CT,0);
        add(0,1,8'hE0,H_CT,0); add(0,1,8'hF0,H_CT,0); add(0,1,8'h14,0,0);
        add(0,1,8'h14,0,0); add(0,0,8'h00,0,0);
        // Pause sequence ignored while W held, then Enter
        add(0,1,8'h1D,H_W,0);
        add(0,1,8'hE1,H_W,0); add(0,1,8'h14,H_W,0); add(0,1,8'h77,H_W,0); add(0,1,8'hE1,H_W,0);
        add(0,1,8'hF0,H_W,0); add(0,1,8'h14,H_W,0); add(0,1,8'hF0,H_W,0); add(0,1,8'h77,H_W,0);
        add(0,1,8'h5A,H_W|H_EN,P_ST); add(0,0,8'h00,H_W|H_EN,0);
        add(0,1,8'hF0,H_W|H_EN,0); add(0,1,8'h5A,H_W,0);
        add(0,1,8'hE0,H_W,0); add(0,1,8'h5A,H_W,0); add(0,0,8'h00,H_W,0);
        add(0,1,8'hF0,H_W,0); add(0,1,8'h1D,0,0);
        // clear_keys beats a same-cycle strobe, keys re-register on next make
        add(0,1,8'h1D,H_W,0); add(0,1,8'h23,H_W|H_D,0);
        add(1,1,8'h1C,0,0); add(0,0,8'h00,0,0);
        add(0,1,8'h29,H_SP,P_B1); add(0,0,8'h00,H_SP,0);
        add(0,1,8'hF0,H_SP,0); add(0,1,8'h29,0,0);

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_state", 11'h000, 3'b000);
        reset_n = 1'b1;
        @(negedge clock);
        check("after_reset_idle", 11'h000, 3'b000);

        foreach (vecs[i]) begin
            cycle(vecs[i].clr, vecs[i].en, vecs[i].b);
            check($sformatf("vec%0d_b%02h", i, vecs[i].b), vecs[i].held, vecs[i].pulse);
        end

        // Timeout: T idle cycles after E0 abandons it, so 23 is plain D
        send(8'hE0);
        repeat (T) cycle(1'b0, 1'b0, 8'h00);
        send(8'h23);
        check("timeout_plain_d", H_D, 3'b000);
        send(8'hF0); send(8'h23);
        check("timeout_release_d", 11'h000, 3'b000);
        // One cycle short of the timeout: E0 still pending
        send(8'hE0);
        repeat (T-1) cycle(1'b0, 1'b0, 8'h00);
        send(8'h74);
        check("timeout_edge_ext", H_RT, 3'b000);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("timeout_edge_release", 11'h000, 3'b000);

        // Asynchronous reset after F0 drops the partial break
        send(8'h1D);
        send(8'hF0);
        #1 reset_n = 1'b0;
        #2 check("async_reset_mid", 11'h000, 3'b000);
        @(negedge clock);
        reset_n = 1'b1;
        send(8'h1B);
        check("after_reset_make_s", H_S, 3'b000);

        // Randomized traffic against the model
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        q.delete(); m_held = '0; m_pulse = '0; idle = 0;
        for (int ev = 0; ev < 1500; ev++) begin
            logic [7:0] pool[17];
            int gap;
            logic clr;
            pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h75, 8'h6B, 8'h72, 8'h74,
                     8'h14, 8'h5A, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'h00};
            pool[16] = 8'($urandom);
            gap = $urandom_range(0, 9);
            if (gap == 0) gap = T - 1 + $urandom_range(0, 2);
            else gap = gap - 1;
            if (gap > 4 && gap < T - 1) gap = 0;
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 1'b0, 8'h00);
                check($sformatf("rand%0d_idle", ev), m_held, m_pulse);
            end
            clr = ($urandom_range(0, 39) == 0);
            cycle(clr, 1'b1, pool[$urandom_range(0, 16)]);
            check($sformatf("rand%0d", ev), m_held, m_pulse);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keyboard_decoder.md
Name: keyboard_decoder

Overview:
- Upstream of the game datapath. Takes the byte stream from the PS/2 receiver and parses make, break, E0-extended and E1-pause sequences.
- Tracks held state for 11 game keys and drives the per-player movement and bomb inputs of the datapath, plus a start pulse for the control FSM.
- Owns typematic-repeat suppression and recovery from corrupted or truncated sequences.

Parameters:
- TIMEOUT_CYCLES, 500000: idle cycles (10 ms at 50 MHz) after which a partial sequence is abandoned.
- TO_W, 19: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- ps2_byte  in  8  received scancode byte
- ps2_byte_en  in  1  one-cycle strobe; ps2_byte valid
- clear_keys  in  1  synchronous: release all keys and return to IDLE (driven on player_reset)
- p1_xmov, p1_xdir, p1_ymov, p1_ydir  out  1 each  P1 movement (dir 1 = increasing coordinate)
- p2_xmov, p2_xdir, p2_ymov, p2_ydir  out  1 each  P2 movement
- p1_bomb, p2_bomb  out  1 each  one-cycle bomb-place pulse
- start  out  1  one-cycle pulse on Enter make
- held  out  11  held-key vector, for debug LEDs

Behaviour:
- Clock and reset: one clock, `clock`. `reset_n` is asynchronous and active-low.
- Reset values: all outputs 0, held=0, FSM=IDLE, timeout counter=0, skip counter=0.
- Key map:
  - P1 (non-extended): W 1D=up, A 1C=left, S 1B=down, D 23=right, Space 29=bomb.
  - P2 (E0-extended): up 75, left 6B, down 72, right 74, right-Ctrl 14=bomb.
  - Enter 5A (non-extended) = start.
  - E0 5A is not Enter. Non-extended 14 (left Ctrl) is unmapped.
- Parser FSM, evaluated only on ps2_byte_en:
  - IDLE: E0->EXT; F0->BRK; E1->SKIP with skip_cnt=7; any other byte is a make, decoded with ext=0, stay IDLE.
  - EXT: F0->EXT_BRK; any other byte is a make with ext=1, ->IDLE.
  - BRK: any byte is a break with ext=0, ->IDLE.
  - EXT_BRK: any byte is a break with ext=1, ->IDLE.
  - SKIP: decrement skip_cnt on each byte; ->IDLE when it reaches 0. The whole Pause sequence (8 bytes) is ignored.
  - Unmapped codes: FSM advances normally, no held change.
- Timeout:
  - Counter clears on every strobe.
  - In any state other than IDLE it increments each cycle. At TIMEOUT_CYCLES-1 the FSM goes to IDLE and the counter clears.
  - In IDLE the counter holds at 0.
- Held update:
  - Make sets the key's held bit; break clears it.
  - Break of a key not held: no-op. Repeated make of a held key (typematic): held stays 1.
- Pulses:
  - p1_bomb, p2_bomb and start are registered and high for exactly one cycle.
  - They fire only on a make whose held bit was 0 before that edge. Typematic repeats never re-fire.
- Movement (combinational from held):
  - xmov = left XOR right; xdir = right AND NOT left.
  - ymov = up XOR down; ydir = down AND NOT up.
  - Both keys of an axis held gives mov=0, dir=0. Both axes may be active at once.
- Latency: held, movement outputs and pulses reflect the final byte of a sequence in the cycle after its strobe cycle.
- clear_keys:
  - Takes priority over ps2_byte_en in the same cycle; that byte is dropped.
  - held=0, FSM=IDLE, counters=0, no pulse generated.
  - Keys still physically down re-register only on their next typematic make, which fires a bomb/start pulse.
- reset_n asserted mid-sequence: immediate return to the reset values above; partial sequence lost.

Decomposition:
- Package kbd_pkg:
  - scancode constants: SC_E0, SC_E1, SC_F0 and the 11 key codes;
  - key index localparams KEY_P1_UP..KEY_START (0..10);
  - FSM state encoding.
- Sub-module scancode_parser:
  - contains the FSM, timeout counter and skip counter;
  - outputs code[7:0], ext, brk, code_valid (1-cycle);
  - the top level maps codes to key indices and owns held and the pulse logic.

Test Plan:
- `1D` strobe -> next cycle p1_ymov=1, p1_ydir=0. Then `F0 1D` -> p1_ymov=0 the cycle after the 1D strobe.
- `E0 74`, then `E0 6B` -> p2_xmov=1, p2_xdir=1 after the first pair; p2_xmov=0, p2_xdir=0 after the second. Then `E0 F0 74` -> p2_xmov=1, p2_xdir=0.
- `29` sent 3 times, then `F0 29`, then `29` -> exactly 2 p1_bomb pulses, each 1 cycle wide. `E0 14` -> one p2_bomb pulse. Left Ctrl `14` -> no pulse.
- `E1 14 77 E1 F0 14 F0 77`, then `5A` -> held unchanged through the pause sequence; single start pulse after 5A. `E0 5A` -> no start pulse.
- `E0`, then no strobe for TIMEOUT_CYCLES cycles (TIMEOUT_CYCLES=16 in sim), then `23` -> decoded as non-extended D: p1_xmov=1, p1_xdir=1.
- Hold W and D, assert clear_keys together with a `1C` strobe -> held=0, all movement outputs 0, no pulses. Then `29` -> one p1_bomb pulse. reset_n pulsed after `F0` -> a following `1B` is treated as a make.
